// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add MULT/MULTU and restoring DIV/DIVU into HI/LO,
// with a start/busy/done handshake and direct MTHI/MTLO writes.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AccW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateE;

  stateE            state;
  logic [CntW-1:0]  cnt;
  logic [AccW-1:0]  acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] aHold;
  logic             isDiv;
  logic             negA;
  logic             negRes;
  logic             divZero;

  // Operand sign handling at start; op[0]=0 selects the signed variants.
  logic             isSigned;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;

  assign isSigned = ~op[0];
  assign aNeg     = isSigned & A[WIDTH-1];
  assign bNeg     = isSigned & B[WIDTH-1];
  assign aMag     = aNeg ? WIDTH'(-A) : A;
  assign bMag     = bNeg ? WIDTH'(-B) : B;

  // One iteration: multiply adds the multiplicand into the upper half then shifts right;
  // divide shifts the partial remainder left and subtracts the divisor when it fits.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divTrial;
  logic             divFits;
  logic [WIDTH-1:0] divRem;

  assign mulSum   = {1'b0, acc[AccW-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  assign divTrial = acc[AccW-1:WIDTH-1] - {1'b0, mcand};
  assign divFits  = ~divTrial[WIDTH];
  assign divRem   = divFits ? divTrial[WIDTH-1:0] : acc[AccW-2:WIDTH-1];

  // Sign-corrected results for the FIX cycle.
  logic [AccW-1:0]  prodFix;
  logic [WIDTH-1:0] quotFix;
  logic [WIDTH-1:0] remFix;

  assign prodFix = negRes ? AccW'(-acc) : acc;
  assign quotFix = negRes ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign remFix  = negA ? WIDTH'(-acc[AccW-1:WIDTH]) : acc[AccW-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      aHold   <= '0;
      isDiv   <= 1'b0;
      negA    <= 1'b0;
      negRes  <= 1'b0;
      divZero <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isDiv   <= op[1];
            negA    <= aNeg;
            negRes  <= aNeg ^ bNeg;
            divZero <= (B == '0);
            aHold   <= A;
            mcand   <= bMag;
            acc     <= {{WIDTH{1'b0}}, aMag};
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          if (isDiv) acc <= {divRem, acc[WIDTH-2:0], divFits};
          else       acc <= {mulSum, acc[WIDTH-1:1]};
          cnt <= cnt + CntW'(1);
          if (cnt == CntW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!isDiv) begin
            hi <= prodFix[AccW-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
          end else if (divZero) begin
            hi <= aHold;
            lo <= '1;
          end else begin
            hi <= remFix;
            lo <= quotFix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO are queued at start, and a monitor
// checks every done pulse against them, including the start-to-done latency.
module tb_muldiv_unit;

  localparam int unsigned W       = 32;
  localparam int unsigned Latency = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  A, B, wdata;
  logic [1:0]    op;
  logic          start, hi_we, lo_we;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .op(op), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [63:0] expQ[$];
  int unsigned e0Q[$];
  string       nameQ[$];
  int          nChecks = 0;
  int          nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like the ISA.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: begin p = sa * sb; return 64'(p); end
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest pending operation.
  logic [63:0] monExp;
  int unsigned monE0;
  string       monName;
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expQ.size() == 0) begin
        check("done without pending op", 64'(done), 64'(0));
      end else begin
        monExp  = expQ.pop_front();
        monE0   = e0Q.pop_front();
        monName = nameQ.pop_front();
        check({monName, " hi"}, 64'(hi), 64'(monExp[63:32]));
        check({monName, " lo"}, 64'(lo), 64'(monExp[31:0]));
        check({monName, " latency"}, 64'(cycle - monE0), 64'(Latency));
      end
    end
  end

  // Drives start for one edge, queues the expected result, then scrambles operands.
  task automatic startOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string nm);
    A = a; B = b; op = o; start = 1'b1;
    expQ.push_back(model(o, a, b));
    e0Q.push_back(cycle + 1);
    nameQ.push_back(nm);
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); op = 2'($urandom);
  endtask

  task automatic waitIdle(input string nm);
    for (int k = 0; k < 200 && expQ.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (expQ.size() != 0) begin
      check({nm, " timeout, pending ops"}, 64'(expQ.size()), 64'(0));
      expQ.delete(); e0Q.delete(); nameQ.delete();
    end
  endtask

  logic [W-1:0] prevHi, prevLo;
  logic [1:0]   rop;
  logic [W-1:0] ra, rb;

  initial begin
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    A = '0; B = '0; op = '0; wdata = '0;
    repeat (3) @(posedge clk); #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // MULTU max*max with busy profile and HI/LO stable through RUN.
    prevHi = hi; prevLo = lo;
    startOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
    for (int i = 0; i < int'(Latency); i++) begin
      check("busy during op", 64'(busy), 64'(1));
      check("hi/lo stable during op", {hi, lo}, {prevHi, prevLo});
      @(posedge clk); #1;
    end
    check("busy after op", 64'(busy), 64'(0));
    check("done after op", 64'(done), 64'(1));
    waitIdle("multu max");
    check("multu max hi const", 64'(hi), 64'(32'hFFFF_FFFE));
    check("multu max lo const", 64'(lo), 64'(32'h0000_0001));

    startOp(2'b00, 32'hFFFF_FFFD, 32'd5, "mult -3*5");
    waitIdle("mult -3*5");
    check("mult -3*5 lo const", 64'(lo), 64'(32'hFFFF_FFF1));
    startOp(2'b10, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    waitIdle("div -7/2");
    check("div -7/2 lo const", 64'(lo), 64'(32'hFFFF_FFFD));
    check("div -7/2 hi const", 64'(hi), 64'(32'hFFFF_FFFF));

    startOp(2'b11, 32'h0000_1234, 32'd0, "divu by zero");
    waitIdle("divu by zero");
    check("divu by zero lo const", 64'(lo), 64'(32'hFFFF_FFFF));
    startOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
    waitIdle("div overflow");
    check("div overflow lo const", 64'(lo), 64'(32'h8000_0000));
    startOp(2'b10, 32'hFFFF_FFF9, 32'd0, "div by zero signed");
    waitIdle("div by zero signed");

    // Start and MTHI while busy must both be ignored.
    startOp(2'b11, 32'd100, 32'd7, "divu 100/7");
    repeat (9) begin @(posedge clk); #1; end
    prevHi = hi;
    start = 1'b1; op = 2'b01; A = 32'd3; B = 32'd3; hi_we = 1'b1; wdata = 32'hAA;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("busy after ignored start", 64'(busy), 64'(1));
    check("hi after ignored mthi", 64'(hi), 64'(prevHi));
    waitIdle("divu 100/7");
    check("divu 100/7 hi const", 64'(hi), 64'(2));
    check("divu 100/7 lo const", 64'(lo), 64'(14));

    // MTHI/MTLO together, then MTLO colliding with start.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi", 64'(hi), 64'(32'h1234_5678));
    check("mtlo", 64'(lo), 64'(32'h1234_5678));
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    startOp(2'b01, 32'd9, 32'd9, "multu with mtlo");
    lo_we = 1'b0;
    check("mtlo dropped on start", 64'(lo), 64'(32'h1234_5678));
    waitIdle("multu with mtlo");

    // Asynchronous reset in the middle of an operation.
    startOp(2'b00, 32'hFFFF_F000, 32'h0001_2345, "mult aborted");
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort hi", 64'(hi), 64'(0));
    check("abort lo", 64'(lo), 64'(0));
    expQ.delete(); e0Q.delete(); nameQ.delete();
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    startOp(2'b01, 32'd6, 32'd7, "multu 6*7");
    waitIdle("multu 6*7");
    check("multu 6*7 lo const", 64'(lo), 64'(42));
    check("multu 6*7 hi const", 64'(hi), 64'(0));

    // Random back-to-back operations: each new start lands in the done cycle.
    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom);
      ra  = pickOperand();
      rb  = pickOperand();
      startOp(rop, ra, rb, $sformatf("rand%0d op%0d %h,%h", n, rop, ra, rb));
      for (int k = 0; k < 60 && !done; k++) begin
        @(posedge clk); #1;
      end
      if (!done) check("rand done timeout", 64'(done), 64'(1));
    end
    waitIdle("random");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
